// File: rtl/fu_pkg.sv
// Shared types and default latencies for the functional-unit scheduler.
package fu_pkg;

  typedef enum logic [1:0] {
    FuAlu = 2'd0,
    FuMul = 2'd1,
    FuDiv = 2'd2
  } fu_class_t;

  localparam int unsigned CdbWidth = 2;
  localparam int unsigned AluLat   = 1;
  localparam int unsigned MulLat   = 4;
  localparam int unsigned DivLat   = 16;
  localparam int unsigned Horizon  = 16;

  localparam int unsigned CdbCntW = $clog2(CdbWidth + 1);
  typedef logic [CdbCntW-1:0] cdb_cnt_t;

endpackage

// File: rtl/cdb_resv.sv
// CDB reservation shift table: per-offset port counts, shifted every cycle.
module cdb_resv #(
  parameter int unsigned CDB_WIDTH = 2,
  parameter int unsigned HORIZON   = 16,
  localparam int unsigned CW       = $clog2(CDB_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [HORIZON*CW-1:0] claim,
  output logic [HORIZON*CW-1:0] lookup,
  output logic [CW-1:0]         head
);

  // resv_q[i] counts ports taken i cycles from now; lookup field i (offset i+1)
  // is the shifted view, i.e. ports taken i+1 cycles from now.
  logic [CW-1:0] resv_q [HORIZON];

  assign head = resv_q[0];

  always_comb begin
    lookup = '0;
    for (int i = 0; i < HORIZON - 1; i++) begin
      lookup[i*CW +: CW] = resv_q[i+1];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < HORIZON; i++) begin
      if (reset) begin
        resv_q[i] <= '0;
      end else begin
        resv_q[i] <= lookup[i*CW +: CW] + claim[i*CW +: CW];
      end
    end
  end

endmodule

// File: rtl/fu_scheduler.sv
// FU scheduler: issue availability per class, divider occupancy, CDB slot
// reservation and leftover-bandwidth grant for the memory unit.
module fu_scheduler
  import fu_pkg::*;
#(
  parameter int unsigned CDB_WIDTH = CdbWidth,
  parameter int unsigned ALU_LAT   = AluLat,
  parameter int unsigned MUL_LAT   = MulLat,
  parameter int unsigned DIV_LAT   = DivLat,
  parameter int unsigned HORIZON   = Horizon,
  localparam int unsigned CW       = $clog2(CDB_WIDTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  output logic [2:0]    avail,
  input  logic [2:0]    issue_valid,
  input  logic          flush,
  input  logic          mem_req,
  output logic          mem_grant,
  output logic [CW-1:0] cdb_used,
  output logic          div_busy
);

  localparam int unsigned DCW = $clog2(DIV_LAT + 1);

  logic [HORIZON*CW-1:0] claim;
  logic [HORIZON*CW-1:0] lookup;
  logic [DCW-1:0]        div_cnt;
  logic [2:0]            go;
  int unsigned           lvl_alu, lvl_mul, lvl_div;

  assign go       = issue_valid & {3{~flush}};
  assign div_busy = (div_cnt != '0);

  // Fixed priority ALU > MUL > DIV: each level sees higher-priority claims.
  always_comb begin
    lvl_alu = 32'(lookup[(ALU_LAT-1)*CW +: CW]);
    lvl_mul = 32'(lookup[(MUL_LAT-1)*CW +: CW])
            + 32'(go[FuAlu] && (ALU_LAT == MUL_LAT));
    lvl_div = 32'(lookup[(DIV_LAT-1)*CW +: CW])
            + 32'(go[FuAlu] && (ALU_LAT == DIV_LAT))
            + 32'(go[FuMul] && (MUL_LAT == DIV_LAT));

    avail        = '0;
    avail[FuAlu] = (lvl_alu < CDB_WIDTH);
    avail[FuMul] = (lvl_mul < CDB_WIDTH);
    avail[FuDiv] = !div_busy && (lvl_div < CDB_WIDTH);

    claim = '0;
    claim[(ALU_LAT-1)*CW +: CW] = claim[(ALU_LAT-1)*CW +: CW] + CW'(go[FuAlu]);
    claim[(MUL_LAT-1)*CW +: CW] = claim[(MUL_LAT-1)*CW +: CW] + CW'(go[FuMul]);
    claim[(DIV_LAT-1)*CW +: CW] = claim[(DIV_LAT-1)*CW +: CW] + CW'(go[FuDiv]);
  end

  cdb_resv #(
    .CDB_WIDTH (CDB_WIDTH),
    .HORIZON   (HORIZON)
  ) u_cdb_resv (
    .clock  (clock),
    .reset  (reset),
    .claim  (claim),
    .lookup (lookup),
    .head   (cdb_used)
  );

  assign mem_grant = mem_req && (32'(cdb_used) < CDB_WIDTH);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      div_cnt <= '0;
    end else if (go[FuDiv]) begin
      div_cnt <= DCW'(DIV_LAT - 1);
    end else if (div_busy) begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ((go & ~avail) == 3'b000);
    end
  end

endmodule

// File: tb/tb_fu_scheduler.sv
// Directed bench for fu_scheduler with a queue of expected CDB write-back cycles.
module tb_fu_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] issue_valid = 3'b000;
  logic       flush = 1'b0;
  logic       mem_req = 1'b0;
  logic [2:0] avail;
  logic       mem_grant;
  logic [1:0] cdb_used;
  logic       div_busy;

  logic [2:0] iv1 = 3'b000;
  logic [2:0] avail1;
  logic       mg1;
  logic [1:0] cu1;
  logic       db1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_cnt    = 0;
  int sb[$];

  always #5 clock = ~clock;

  fu_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .avail       (avail),
    .issue_valid (issue_valid),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_grant   (mem_grant),
    .cdb_used    (cdb_used),
    .div_busy    (div_busy)
  );

  fu_scheduler #(
    .MUL_LAT (1),
    .DIV_LAT (1),
    .HORIZON (4)
  ) dut1 (
    .clock       (clock),
    .reset       (reset),
    .avail       (avail1),
    .issue_valid (iv1),
    .flush       (1'b0),
    .mem_req     (1'b0),
    .mem_grant   (mg1),
    .cdb_used    (cu1),
    .div_busy    (db1)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 16;
  endfunction

  function automatic int due_cnt(input int c);
    int n = 0;
    foreach (sb[i]) if (sb[i] == c) n++;
    return n;
  endfunction

  // One cycle on the default instance: drive, check mid-cycle, advance model.
  task automatic tick(input logic [2:0] iv, input logic fl, input logic mr, input logic rs);
    logic [2:0] go;
    logic [2:0] av;
    int         lvl;
    int         ecdb;
    int         keep[$];
    issue_valid = iv;
    flush       = fl;
    mem_req     = mr;
    reset       = rs;
    go          = fl ? 3'b000 : iv;
    #2;
    if (!rs) begin
      ecdb = due_cnt(cyc);
      for (int k = 0; k < 3; k++) begin
        lvl = due_cnt(cyc + lat_of(k));
        for (int j = 0; j < k; j++) if (go[j] && lat_of(j) == lat_of(k)) lvl++;
        av[k] = (lvl < 2);
      end
      if (m_cnt != 0) av[2] = 1'b0;
      chk("avail", int'(avail), int'(av));
      chk("cdb_used", int'(cdb_used), ecdb);
      chk("mem_grant", int'(mem_grant), int'(mr && ecdb < 2));
      chk("div_busy", int'(div_busy), int'(m_cnt != 0));
    end
    @(posedge clock);
    #1;
    if (rs) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      foreach (sb[i]) if (sb[i] > cyc) keep.push_back(sb[i]);
      sb = keep;
      for (int k = 0; k < 3; k++) if (go[k]) sb.push_back(cyc + lat_of(k));
      if (fl) m_cnt = 0;
      else if (go[2]) m_cnt = 15;
      else if (m_cnt > 0) m_cnt--;
    end
    cyc++;
  endtask

  initial begin
    tick(3'b000, 1'b0, 1'b0, 1'b1);
    tick(3'b000, 1'b0, 1'b0, 1'b1);

    // Idle after reset with memory request pending
    tick(3'b000, 1'b0, 1'b1, 1'b0);
    chk("u1_reset_avail", int'(avail1), 7);
    chk("u1_reset_cdb", int'(cu1), 0);
    chk("u1_reset_busy", int'(db1), 0);

    // ALU and MUL every cycle, memory starved once the CDB fills
    repeat (8) tick(3'b011, 1'b0, 1'b1, 1'b0);
    repeat (6) tick(3'b000, 1'b0, 1'b1, 1'b0);

    // Lone divide: busy window and write-back 16 cycles later
    tick(3'b100, 1'b0, 1'b1, 1'b0);
    repeat (17) tick(3'b000, 1'b0, 1'b1, 1'b0);

    // Divide then flush at t=3: divider freed, reservation retained
    tick(3'b100, 1'b0, 1'b0, 1'b0);
    repeat (2) tick(3'b000, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b1, 1'b0, 1'b0);
    repeat (14) tick(3'b000, 1'b0, 1'b0, 1'b0);

    // Flush with divide issue: issue ignored entirely
    tick(3'b100, 1'b1, 1'b0, 1'b0);
    repeat (17) tick(3'b000, 1'b0, 1'b1, 1'b0);

    // Reset mid-divide drops busy and reservations
    tick(3'b100, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0, 1'b1);
    repeat (17) tick(3'b000, 1'b0, 1'b1, 1'b0);

    // Same-offset claims on the single-cycle instance
    iv1 = 3'b011;
    #2;
    chk("u1_avail_pair", int'(avail1), 3);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    iv1 = 3'b000;
    #2;
    chk("u1_cdb_pair", int'(cu1), 2);
    chk("u1_avail_after", int'(avail1), 7);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    iv1 = 3'b001;
    #2;
    chk("u1_avail_alu", int'(avail1), 7);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    iv1 = 3'b000;
    #2;
    chk("u1_cdb_alu", int'(cu1), 1);
    tick(3'b000, 1'b0, 1'b0, 1'b0);
    chk("u1_cdb_drain", int'(cu1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
